fb_fill_engine: RTL

- Hardware rectangle-fill writer for the 320x240, 12-bit frame buffer in the CPU clock domain.
- The CPU programs origin, size and colour, then starts the engine. The engine writes one pixel per cycle into the display block's CPU write port (mem_write/mem_addr/mem_wdata).
- Direct CPU pixel writes pass through the engine. They take priority over the fill and stall it for one cycle each.

---
 rtl/fb_fill_engine_pkg.sv | 34 +++
 rtl/fb_fill_engine_if.sv | 32 +++
 rtl/fb_rect_clip.sv | 30 +++
 rtl/fb_fill_engine.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fb_fill_engine_pkg.sv
// Shared constants, register map and FSM encoding for the
// frame buffer rectangle-fill engine and later blit engines.
package fb_fill_engine_pkg;

    localparam int FB_W   = 320;
    localparam int FB_H   = 240;
    localparam int ADDR_W = 17;

    localparam logic [1:0] REG_ORIGIN = 2'd0;
    localparam logic [1:0] REG_SIZE   = 2'd1;
    localparam logic [1:0] REG_COLOR  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2
    } state_e;

    // y*320 as (y<<8)+(y<<6), keeping the datapath multiplier-free
    function automatic logic [ADDR_W-1:0] row_addr(
        input logic [8:0] y
    );
        logic [ADDR_W-1:0] ye;
        ye = ADDR_W'(y);
        return (ye << 8) + (ye << 6);
    endfunction

endpackage

// File: rtl/fb_fill_engine_if.sv
// CPU register, direct pixel write and frame buffer
// write port bundle of the fill engine.
interface fb_fill_engine_if;
    import fb_fill_engine_pkg::*;

    logic              reg_write;
    logic [1:0]        reg_addr;
    logic [31:0]       reg_wdata;
    logic [31:0]       reg_rdata;
    logic              cpu_fb_write;
    logic [ADDR_W-1:0] cpu_fb_addr;
    logic [31:0]       cpu_fb_wdata;
    logic              fb_write;
    logic [ADDR_W-1:0] fb_addr;
    logic [31:0]       fb_wdata;
    logic              done_pulse;

    modport master (
        output reg_write, reg_addr, reg_wdata,
        output cpu_fb_write, cpu_fb_addr, cpu_fb_wdata,
        input  reg_rdata, fb_write, fb_addr, fb_wdata,
        input  done_pulse
    );

    modport slave (
        input  reg_write, reg_addr, reg_wdata,
        input  cpu_fb_write, cpu_fb_addr, cpu_fb_wdata,
        output reg_rdata, fb_write, fb_addr, fb_wdata,
        output done_pulse
    );

endinterface

// File: rtl/fb_rect_clip.sv
// Combinational clip of a rectangle against the frame
// buffer; empty when nothing of it lies on screen.
module fb_rect_clip
    import fb_fill_engine_pkg::*;
(
    input  logic [8:0] x0,
    input  logic [8:0] y0,
    input  logic [9:0] w,
    input  logic [9:0] h,
    output logic [9:0] w_eff,
    output logic [9:0] h_eff,
    output logic       empty
);

    logic [9:0] room_x;
    logic [9:0] room_y;
    logic       off_x;
    logic       off_y;

    always_comb begin
        off_x  = {1'b0, x0} >= 10'(FB_W);
        off_y  = {1'b0, y0} >= 10'(FB_H);
        room_x = 10'(FB_W) - {1'b0, x0};
        room_y = 10'(FB_H) - {1'b0, y0};
        empty  = off_x || off_y || (w == 10'd0) || (h == 10'd0);
        w_eff  = (w < room_x) ? w : room_x;
        h_eff  = (h < room_y) ? h : room_y;
    end

endmodule

// File: rtl/fb_fill_engine.sv
// Rectangle-fill writer for the 320x240 frame buffer with
// direct CPU pixel writes passed through at priority.
module fb_fill_engine
    import fb_fill_engine_pkg::*;
(
    input  logic            clk_cpu,
    input  logic            reset_n,
    fb_fill_engine_if.slave bus
);

    state_e            state;
    state_e            state_n;
    logic [8:0]        x0_q;
    logic [8:0]        y0_q;
    logic [9:0]        w_q;
    logic [9:0]        h_q;
    logic [11:0]       color_q;
    logic              done_q;
    logic [11:0]       colour_l;
    logic [8:0]        x0_l;
    logic [9:0]        w_eff_l;
    logic [9:0]        h_eff_l;
    logic [9:0]        col;
    logic [9:0]        row;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] pix_addr;
    logic              fin_q;
    logic [9:0]        clip_w;
    logic [9:0]        clip_h;
    logic              clip_empty;
    logic              wr_origin;
    logic              wr_size;
    logic              wr_color;
    logic              wr_ctrl;
    logic              start;
    logic              clr_done;
    logic              busy;
    logic              setup_empty;
    logic              fill_step;
    logic              col_last;
    logic              last_pix;
    logic              fb_write_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [31:0]       fb_wdata_q;
    logic              done_pulse_q;
    logic              unused_bits;

    fb_rect_clip u_clip (
        .x0   (x0_q),
        .y0   (y0_q),
        .w    (w_q),
        .h    (h_q),
        .w_eff(clip_w),
        .h_eff(clip_h),
        .empty(clip_empty)
    );

    assign busy      = (state != ST_IDLE);
    assign wr_origin = bus.reg_write && (bus.reg_addr == REG_ORIGIN);
    assign wr_size   = bus.reg_write && (bus.reg_addr == REG_SIZE);
    assign wr_color  = bus.reg_write && (bus.reg_addr == REG_COLOR);
    assign wr_ctrl   = bus.reg_write && (bus.reg_addr == REG_CTRL);
    assign start     = wr_ctrl && bus.reg_wdata[CTRL_START] && !busy;
    assign clr_done  = wr_ctrl && bus.reg_wdata[CTRL_CLR_DONE];
    assign col_last  = (col == w_eff_l - 10'd1);
    assign last_pix  = col_last && (row == h_eff_l - 10'd1);
    assign pix_addr  = row_base + ADDR_W'(x0_l) + ADDR_W'(col);

    assign unused_bits = ^{bus.reg_wdata[31:26],
                           bus.reg_wdata[15:12],
                           bus.cpu_fb_wdata[31:12]};

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        setup_empty = 1'b0;
        fill_step   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_n = ST_SETUP;
            end
            ST_SETUP: begin
                if (clip_empty) begin
                    state_n     = ST_IDLE;
                    setup_empty = 1'b1;
                end else begin
                    state_n = ST_FILL;
                end
            end
            ST_FILL: begin
                // a CPU pixel write owns the port; the fill holds
                if (!bus.cpu_fb_write) begin
                    fill_step = 1'b1;
                    if (last_pix) state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            color_q      <= '0;
            done_q       <= 1'b0;
            colour_l     <= '0;
            x0_l         <= '0;
            w_eff_l      <= '0;
            h_eff_l      <= '0;
            col          <= '0;
            row          <= '0;
            row_base     <= '0;
            fin_q        <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            unique case (1'b1)
                wr_origin: begin
                    x0_q <= bus.reg_wdata[8:0];
                    y0_q <= bus.reg_wdata[24:16];
                end
                wr_size: begin
                    w_q <= bus.reg_wdata[9:0];
                    h_q <= bus.reg_wdata[25:16];
                end
                wr_color: color_q <= bus.reg_wdata[11:0];
                default: ;
            endcase
            if (state == ST_SETUP) begin
                colour_l <= color_q;
                x0_l     <= x0_q;
                w_eff_l  <= clip_w;
                h_eff_l  <= clip_h;
                row_base <= row_addr(y0_q);
                col      <= '0;
                row      <= '0;
            end else if (fill_step && !last_pix) begin
                if (col_last) begin
                    col      <= '0;
                    row      <= row + 10'd1;
                    row_base <= row_base + ADDR_W'(FB_W);
                end else begin
                    col <= col + 10'd1;
                end
            end
            // completion is reported after the last pixel leaves
            fin_q        <= fill_step && last_pix;
            done_pulse_q <= setup_empty || fin_q;
            if (setup_empty || fin_q)  done_q <= 1'b1;
            else if (start || clr_done) done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            fb_write_q <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
        end else if (bus.cpu_fb_write) begin
            fb_write_q <= 1'b1;
            fb_addr_q  <= bus.cpu_fb_addr;
            fb_wdata_q <= {20'b0, bus.cpu_fb_wdata[11:0]};
        end else if (fill_step) begin
            fb_write_q <= 1'b1;
            fb_addr_q  <= pix_addr;
            fb_wdata_q <= {20'b0, colour_l};
        end else begin
            fb_write_q <= 1'b0;
        end
    end

    always_comb begin
        bus.reg_rdata            = '0;
        bus.reg_rdata[STAT_BUSY] = busy;
        bus.reg_rdata[STAT_DONE] = done_q;
    end

    assign bus.fb_write   = fb_write_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_wdata   = fb_wdata_q;
    assign bus.done_pulse = done_pulse_q;

endmodule
